module_display_scan: RTL and testbench

//  Scan controller for the 4-digit multiplexed 7-segment display.
//  - Time-multiplexes the digits by driving the 4:1 nibble mux select and the active-low anode lines.
//  - Latches a new 16-bit value through a valid/ready handshake.
//  - Commits that value only at a frame boundary, so a digit scan never shows half-old, half-new data.
//  - Sits between the BCD/value producer and the nibble mux + segment decoder.

---
 rtl/module_display_scan.sv | 89 ++++++++
 tb/tb_module_display_scan.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/module_display_scan.sv
// rtl/module_display_scan.sv - 4-digit 7-segment scan controller with frame-boundary value commit
// Optional: LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 always lit).
module module_display_scan #(
  parameter int REFRESH_DIV = 27000,
  localparam int DIV_W = $clog2(REFRESH_DIV)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [15:0] data_in,
  input  logic        data_valid,
  output logic        data_ready,
  output logic [1:0]  sel,
  output logic [15:0] mux_data,
  output logic [3:0]  an,
  output logic        digit_tick,
  output logic        frame_done
);

  typedef enum logic {EMPTY, FULL} state_t;

  localparam logic [DIV_W-1:0] LAST = DIV_W'(REFRESH_DIV - 1);

  state_t            state, state_nxt;
  logic [DIV_W-1:0]  prescaler;
  logic [15:0]       pending;
  logic [15:0]       mux_nxt;
  logic [1:0]        sel_nxt;
  logic [3:0]        an_nxt;
  logic              tick, accept, commit;

  assign data_ready = (state == EMPTY);

  always_comb begin
    tick      = 1'b0;
    sel_nxt   = sel;
    accept    = 1'b0;
    commit    = 1'b0;
    state_nxt = state;
    mux_nxt   = mux_data;
    an_nxt    = 4'hF;

    tick    = enable && (prescaler == LAST);
    sel_nxt = tick ? sel + 2'd1 : sel;
    accept  = data_valid && (state == EMPTY);
    commit  = (state == FULL) && ((tick && sel == 2'd3) || !enable);

    case (state)
      EMPTY:   if (accept) state_nxt = FULL;
      FULL:    if (commit) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase

    if (commit) mux_nxt = pending;

    // an is derived from next-state sel/mux_data so it always matches the registered sel
    if (enable) begin
      an_nxt = ~(4'b0001 << sel_nxt);
`ifdef LEADING_ZERO_BLANK_EN
      if (sel_nxt != 2'd0 && (mux_nxt >> {sel_nxt, 2'b00}) == 16'h0000)
        an_nxt = 4'hF;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= EMPTY;
      prescaler  <= '0;
      sel        <= 2'd0;
      pending    <= 16'h0000;
      mux_data   <= 16'h0000;
      an         <= 4'hF;
      digit_tick <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      sel        <= sel_nxt;
      mux_data   <= mux_nxt;
      an         <= an_nxt;
      digit_tick <= tick;
      frame_done <= tick && (sel == 2'd3);
      if (!enable || tick) prescaler <= '0;
      else                 prescaler <= prescaler + 1'b1;
      if (accept) pending <= data_in;
    end
  end

endmodule

// File: tb/tb_module_display_scan.sv
// tb/tb_module_display_scan.sv - directed self-checking bench for module_display_scan (REFRESH_DIV=4)
module tb_module_display_scan;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [15:0] data_in;
  logic        data_valid;
  logic        data_ready;
  logic [1:0]  sel;
  logic [15:0] mux_data;
  logic [3:0]  an;
  logic        digit_tick;
  logic        frame_done;

  int passed = 0;
  int total  = 0;

`ifdef LEADING_ZERO_BLANK_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  module_display_scan #(.REFRESH_DIV(4)) dut (
    .clk(clk), .rst(rst), .enable(enable), .data_in(data_in),
    .data_valid(data_valid), .data_ready(data_ready), .sel(sel),
    .mux_data(mux_data), .an(an), .digit_tick(digit_tick), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  function automatic logic [3:0] an_exp(input logic [1:0] s, input logic [15:0] m);
    logic [3:0] a;
    case (s)
      2'd0: a = 4'hE;
      2'd1: a = (LZB && m[15:4]  == 12'h000) ? 4'hF : 4'hD;
      2'd2: a = (LZB && m[15:8]  == 8'h00)   ? 4'hF : 4'hB;
      default: a = (LZB && m[15:12] == 4'h0) ? 4'hF : 4'h7;
    endcase
    return a;
  endfunction

  initial begin
    rst = 1'b1; enable = 1'b1; data_valid = 1'b0; data_in = 16'h0000;
    @(negedge clk);
    @(negedge clk);
    check("rst_sel",   16'(sel),        16'h0);
    check("rst_an",    16'(an),         16'hF);
    check("rst_mux",   mux_data,        16'h0000);
    check("rst_ready", 16'(data_ready), 16'h1);
    check("rst_tick",  16'(digit_tick), 16'h0);
    check("rst_frame", 16'(frame_done), 16'h0);
    rst = 1'b0;

    // scan sequence: edges counted from reset release
    cyc(1);
    check("e1_an",  16'(an),  16'(an_exp(2'd0, 16'h0)));
    check("e1_sel", 16'(sel), 16'h0);
    cyc(3);
    check("e4_sel",  16'(sel),        16'h1);
    check("e4_an",   16'(an),         16'(an_exp(2'd1, 16'h0)));
    check("e4_tick", 16'(digit_tick), 16'h1);
    cyc(1);
    check("e5_tick", 16'(digit_tick), 16'h0);
    cyc(3);
    check("e8_an",  16'(an),  16'(an_exp(2'd2, 16'h0)));
    cyc(4);
    check("e12_an",  16'(an),  16'(an_exp(2'd3, 16'h0)));
    check("e12_sel", 16'(sel), 16'h3);
    check("e12_frame", 16'(frame_done), 16'h0);
    cyc(4);
    check("e16_sel",   16'(sel),        16'h0);
    check("e16_an",    16'(an),         16'hE);
    check("e16_frame", 16'(frame_done), 16'h1);
    cyc(1);
    check("e17_frame", 16'(frame_done), 16'h0);

    // mid-frame accept, commit at the 3->0 wrap
    data_in = 16'h1234; data_valid = 1'b1;
    cyc(1);
    data_valid = 1'b0;
    check("acc_ready", 16'(data_ready), 16'h0);
    check("acc_mux",   mux_data,        16'h0000);
    cyc(13);
    check("e31_mux", mux_data, 16'h0000);
    cyc(1);
    check("e32_mux",   mux_data,        16'h1234);
    check("e32_ready", 16'(data_ready), 16'h1);
    check("e32_frame", 16'(frame_done), 16'h1);

    // accept exactly on the wrap cycle: deferred one frame
    cyc(15);
    data_in = 16'hABCD; data_valid = 1'b1;
    cyc(1);
    data_valid = 1'b0;
    check("e48_frame", 16'(frame_done), 16'h1);
    check("e48_ready", 16'(data_ready), 16'h0);
    check("e48_mux",   mux_data,        16'h1234);
    cyc(15);
    check("e63_mux", mux_data, 16'h1234);
    cyc(1);
    check("e64_mux",   mux_data,        16'hABCD);
    check("e64_ready", 16'(data_ready), 16'h1);

    // valid held while FULL with changing data: first value wins
    data_in = 16'h5678; data_valid = 1'b1;
    cyc(1);
    check("e65_ready", 16'(data_ready), 16'h0);
    data_in = 16'h9999;
    cyc(14);
    check("e79_mux",   mux_data,        16'hABCD);
    check("e79_ready", 16'(data_ready), 16'h0);
    data_in = 16'h1111;
    cyc(1);
    data_valid = 1'b0;
    check("e80_mux",   mux_data,        16'h5678);
    check("e80_ready", 16'(data_ready), 16'h1);

    // disable mid-frame
    cyc(5);
    check("e85_sel", 16'(sel), 16'h1);
    data_in = 16'h4321; data_valid = 1'b1;
    cyc(1);
    data_valid = 1'b0; enable = 1'b0;
    cyc(1);
    check("dis_an",    16'(an),         16'hF);
    check("dis_sel",   16'(sel),        16'h1);
    check("dis_mux",   mux_data,        16'h4321);
    check("dis_ready", 16'(data_ready), 16'h1);
    data_in = 16'h0042; data_valid = 1'b1;
    cyc(1);
    data_valid = 1'b0;
    check("dis_acc_ready", 16'(data_ready), 16'h0);
    cyc(1);
    check("dis_acc_mux",   mux_data,        16'h0042);
    check("dis_acc_ready2", 16'(data_ready), 16'h1);
    cyc(3);
    check("frozen_sel",  16'(sel),        16'h1);
    check("frozen_an",   16'(an),         16'hF);
    check("frozen_tick", 16'(digit_tick), 16'h0);
    enable = 1'b1;
    cyc(1);
    check("ren_an",  16'(an),  16'(an_exp(2'd1, 16'h0042)));
    check("ren_sel", 16'(sel), 16'h1);
    cyc(3);
    check("ren_sel2", 16'(sel),        16'h2);
    check("ren_an2",  16'(an),         16'(an_exp(2'd2, 16'h0042)));
    check("ren_tick", 16'(digit_tick), 16'h1);

    // async reset with pending FULL
    data_in = 16'h7777; data_valid = 1'b1;
    cyc(1);
    data_valid = 1'b0;
    check("pre_rst_ready", 16'(data_ready), 16'h0);
    #2 rst = 1'b1;
    #1;
    check("arst_sel",   16'(sel),        16'h0);
    check("arst_an",    16'(an),         16'hF);
    check("arst_mux",   mux_data,        16'h0000);
    check("arst_ready", 16'(data_ready), 16'h1);
    check("arst_tick",  16'(digit_tick), 16'h0);
    check("arst_frame", 16'(frame_done), 16'h0);
    @(negedge clk);
    rst = 1'b0;
    cyc(1);
    check("post_rst_an",  16'(an),  16'(an_exp(2'd0, 16'h0)));
    check("post_rst_mux", mux_data, 16'h0000);

`ifdef LEADING_ZERO_BLANK_EN
    enable = 1'b0;
    data_in = 16'h0050; data_valid = 1'b1;
    cyc(1);
    data_valid = 1'b0;
    cyc(1);
    check("lzb_mux", mux_data, 16'h0050);
    enable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      check("lzb_an_hi", 16'(an[3:2]), 16'h3);
    end
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
